// File: rtl/err_monitor_bank.sv
// +-----------------------------------------------------------------------+
// | err_monitor_bank: multi-channel error counter bank with a run timer   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
`default_nettype none

module err_monitor_bank #(
  parameter int NCH  = 4,
  parameter int CNTW = 32,
  parameter int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            clear,
  input  logic            mode,
  input  logic [CNTW-1:0] win_len,
  input  logic [NCH-1:0]  err_in,
  input  logic [SELW-1:0] ch_sel,
  output logic [CNTW-1:0] rd_err_cnt,
  output logic [CNTW-1:0] cycle_cnt,
  output logic            busy,
  output logic            done,
  output logic            cnt_full,
  output logic            any_sat
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] C_MAX = '1;
  localparam logic [CNTW-1:0] C_ONE = CNTW'(1);

  state_t          r_state;
  state_t          w_next_state;
  logic [CNTW-1:0] r_err_cnt [NCH];
  logic [CNTW-1:0] r_cycle_cnt;
  logic [CNTW-1:0] r_win_q;
  logic [CNTW-1:0] r_rd_err_cnt;
  logic [NCH-1:0]  r_sat;
  logic            r_cnt_full;
  logic            r_any_sat;

  logic            w_start_run;
  logic            w_count;
  logic [CNTW-1:0] w_cyc_inc;
  logic [NCH-1:0]  w_err_hit;
  logic [NCH-1:0]  w_sat_next;
  logic [CNTW-1:0] w_rd_sel;

  assign w_cyc_inc = (r_cycle_cnt == C_MAX) ? C_MAX : (r_cycle_cnt + C_ONE);

  always_comb begin
    w_next_state = r_state;
    w_start_run  = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_run = 1'b1;
          // A zero-length window completes without ever counting a cycle.
          w_next_state = (mode && (win_len == '0)) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!mode && !start) begin
          w_next_state = S_DONE;
        end else begin
          w_count = 1'b1;
          if ((w_cyc_inc == C_MAX) || (mode && (w_cyc_inc == r_win_q)))
            w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (clear) begin
      w_next_state = S_IDLE;
      w_start_run  = 1'b0;
      w_count      = 1'b0;
    end
  end

  always_comb begin
    w_err_hit  = '0;
    w_sat_next = r_sat;
    w_rd_sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_err_hit[i]  = err_in[i] && (r_err_cnt[i] != C_MAX);
      w_sat_next[i] = r_sat[i] | (w_err_hit[i] && (r_err_cnt[i] == (C_MAX - C_ONE)));
      if (ch_sel == SELW'(i)) w_rd_sel = r_err_cnt[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt  <= '0;
      r_win_q      <= '0;
      r_rd_err_cnt <= '0;
      r_sat        <= '0;
      r_cnt_full   <= 1'b0;
      r_any_sat    <= 1'b0;
      for (int i = 0; i < NCH; i++) r_err_cnt[i] <= '0;
    end else if (clear) begin
      r_cycle_cnt  <= '0;
      r_win_q      <= '0;
      r_rd_err_cnt <= '0;
      r_sat        <= '0;
      r_cnt_full   <= 1'b0;
      r_any_sat    <= 1'b0;
      for (int i = 0; i < NCH; i++) r_err_cnt[i] <= '0;
    end else begin
      r_rd_err_cnt <= w_rd_sel;
      if (w_start_run) begin
        r_cycle_cnt <= '0;
        r_win_q     <= win_len;
        r_sat       <= '0;
        r_cnt_full  <= 1'b0;
        r_any_sat   <= 1'b0;
        for (int i = 0; i < NCH; i++) r_err_cnt[i] <= '0;
      end else if (w_count) begin
        r_cycle_cnt <= w_cyc_inc;
        r_cnt_full  <= r_cnt_full | (w_cyc_inc == C_MAX);
        r_sat       <= w_sat_next;
        r_any_sat   <= |w_sat_next;
        for (int i = 0; i < NCH; i++)
          if (w_err_hit[i]) r_err_cnt[i] <= r_err_cnt[i] + C_ONE;
      end
    end
  end

  assign rd_err_cnt = r_rd_err_cnt;
  assign cycle_cnt  = r_cycle_cnt;
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign cnt_full   = r_cnt_full;
  assign any_sat    = r_any_sat;

endmodule

`default_nettype wire

// File: tb/tb_err_monitor_bank.sv
// Testbench for err_monitor_bank: directed scenarios plus random stimulus
// compared against an integer reference model.
`default_nettype none

module tb_err_monitor_bank;
  localparam int NCH  = 4;
  localparam int CNTW = 8;
  localparam int SELW = 3;
  localparam int MAXV = 255;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DONE = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            clear = 1'b0;
  logic            mode = 1'b0;
  logic [CNTW-1:0] win_len = '0;
  logic [NCH-1:0]  err_in = '0;
  logic [SELW-1:0] ch_sel = '0;
  logic [CNTW-1:0] rd_err_cnt;
  logic [CNTW-1:0] cycle_cnt;
  logic            busy, done, cnt_full, any_sat;

  int total = 0;
  int bad = 0;

  err_monitor_bank #(.NCH(NCH), .CNTW(CNTW), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .win_len(win_len), .err_in(err_in), .ch_sel(ch_sel),
    .rd_err_cnt(rd_err_cnt), .cycle_cnt(cycle_cnt), .busy(busy), .done(done),
    .cnt_full(cnt_full), .any_sat(any_sat)
  );

  always #5 clk = ~clk;

  // Reference model: run phase, counts and flags kept as plain integers.
  int m_phase, m_cyc, m_winq, m_rd;
  int m_err [NCH];
  bit m_sat [NCH];
  bit m_full, m_anysat;

  always @(posedge clk or negedge rst_n) begin : model
    int c;
    int e [NCH];
    bit s [NCH];
    bit a;
    if (!rst_n) begin
      m_phase <= PH_IDLE; m_cyc <= 0; m_winq <= 0; m_rd <= 0;
      m_full <= 0; m_anysat <= 0;
      for (int i = 0; i < NCH; i++) begin m_err[i] <= 0; m_sat[i] <= 0; end
    end else if (clear) begin
      m_phase <= PH_IDLE; m_cyc <= 0; m_winq <= 0; m_rd <= 0;
      m_full <= 0; m_anysat <= 0;
      for (int i = 0; i < NCH; i++) begin m_err[i] <= 0; m_sat[i] <= 0; end
    end else begin
      m_rd <= (int'(ch_sel) < NCH) ? m_err[ch_sel] : 0;
      if (m_phase == PH_IDLE && start) begin
        m_cyc <= 0; m_full <= 0; m_anysat <= 0; m_winq <= int'(win_len);
        for (int i = 0; i < NCH; i++) begin m_err[i] <= 0; m_sat[i] <= 0; end
        m_phase <= (mode && win_len == 0) ? PH_DONE : PH_RUN;
      end else if (m_phase == PH_RUN) begin
        if (!mode && !start) begin
          m_phase <= PH_DONE;
        end else begin
          c = (m_cyc + 1 > MAXV) ? MAXV : m_cyc + 1;
          a = 0;
          for (int i = 0; i < NCH; i++) begin
            e[i] = (err_in[i] && m_err[i] < MAXV) ? m_err[i] + 1 : m_err[i];
            s[i] = m_sat[i] || (e[i] == MAXV);
            a = a | s[i];
            m_err[i] <= e[i];
            m_sat[i] <= s[i];
          end
          m_cyc <= c;
          m_full <= m_full || (c == MAXV);
          m_anysat <= a;
          if (c == MAXV || (mode && c == m_winq)) m_phase <= PH_DONE;
        end
      end else if (m_phase == PH_DONE && !start) begin
        m_phase <= PH_IDLE;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; start = 1'b0; err_in = '0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({rd_err_cnt, cycle_cnt, busy, done, cnt_full, any_sat} !== '0) begin
      bad++;
      $display("FAIL reset: rd=%0d cyc=%0d busy=%b done=%b full=%b sat=%b, want all 0",
               rd_err_cnt, cycle_cnt, busy, done, cnt_full, any_sat);
    end
  endtask

  task automatic test_window();
    int nb = 0;
    int hits [3];
    do_clear();
    hits[0] = $urandom_range(0, 2);
    hits[1] = $urandom_range(3, 6);
    hits[2] = $urandom_range(7, 9);
    mode = 1'b1; win_len = 8'd10; start = 1'b1;
    tick();
    for (int k = 0; k < 30; k++) begin
      if (!busy) break;
      nb++;
      err_in = {1'b0, (k == hits[0] || k == hits[1] || k == hits[2]), 1'b0, 1'b1};
      tick();
    end
    err_in = '0;
    total++;
    if (nb !== 10 || done !== 1'b1 || cycle_cnt !== 8'd10) begin
      bad++;
      $display("FAIL window: busy_cycles=%0d done=%b cyc=%0d, want 10/1/10", nb, done, cycle_cnt);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      ch_sel = SELW'(ch);
      tick();
      total++;
      if (rd_err_cnt !== CNTW'((ch == 0) ? 10 : (ch == 2) ? 3 : 0)) begin
        bad++;
        $display("FAIL window_ch%0d: got %0d want %0d", ch, rd_err_cnt, (ch == 0) ? 10 : (ch == 2) ? 3 : 0);
      end
    end
  endtask

  task automatic test_level();
    do_clear();
    mode = 1'b0; start = 1'b1; ch_sel = 3'd3;
    tick();
    for (int k = 0; k < 25; k++) begin
      err_in = {(k % 5 == 4), 3'b000};
      tick();
    end
    err_in = '0; start = 1'b0;
    tick();
    total++;
    if (done !== 1'b1 || cycle_cnt !== 8'd25 || rd_err_cnt !== 8'd5) begin
      bad++;
      $display("FAIL level_done: done=%b cyc=%0d ch3=%0d, want 1/25/5", done, cycle_cnt, rd_err_cnt);
    end
    tick();
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || cycle_cnt !== 8'd25 || rd_err_cnt !== 8'd5) begin
      bad++;
      $display("FAIL level_idle: done=%b busy=%b cyc=%0d ch3=%0d, want 0/0/25/5",
               done, busy, cycle_cnt, rd_err_cnt);
    end
  endtask

  task automatic test_saturation();
    int nb = 0;
    do_clear();
    mode = 1'b0; start = 1'b1; err_in = 4'b0010; ch_sel = 3'd1;
    tick();
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      nb++;
      tick();
    end
    tick();
    total++;
    if (nb !== 255 || cycle_cnt !== 8'd255 || cnt_full !== 1'b1 || any_sat !== 1'b1 ||
        done !== 1'b1 || rd_err_cnt !== 8'd255) begin
      bad++;
      $display("FAIL saturation: run=%0d cyc=%0d full=%b sat=%b done=%b ch1=%0d, want 255/255/1/1/1/255",
               nb, cycle_cnt, cnt_full, any_sat, done, rd_err_cnt);
    end
    ch_sel = 3'd5;
    tick();
    total++;
    if (rd_err_cnt !== 8'd0) begin
      bad++;
      $display("FAIL sel_range: got %0d want 0", rd_err_cnt);
    end
    err_in = '0;
  endtask

  task automatic test_clear();
    do_clear();
    mode = 1'b1; win_len = 8'd100; start = 1'b1; ch_sel = 3'd0;
    tick();
    for (int k = 0; k < 40; k++) begin
      err_in = 4'($urandom);
      tick();
    end
    err_in = '0; clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || cycle_cnt !== 8'd0 || rd_err_cnt !== 8'd0 ||
        cnt_full !== 1'b0 || any_sat !== 1'b0) begin
      bad++;
      $display("FAIL clear: busy=%b done=%b cyc=%0d rd=%0d, want idle and zero", busy, done, cycle_cnt, rd_err_cnt);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || cycle_cnt !== 8'd1) begin
      bad++;
      $display("FAIL clear_rerun: busy=%b cyc=%0d, want 1/1", busy, cycle_cnt);
    end
  endtask

  task automatic test_edges();
    do_clear();
    mode = 1'b1; win_len = 8'd0; start = 1'b1; ch_sel = 3'd0;
    tick();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || cycle_cnt !== 8'd0) begin
      bad++;
      $display("FAIL win0: done=%b busy=%b cyc=%0d, want 1/0/0", done, busy, cycle_cnt);
    end
    do_clear();
    win_len = 8'd4; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      err_in = 4'b1111;
      tick();
    end
    total++;
    if (done !== 1'b1 || cycle_cnt !== 8'd4 || rd_err_cnt !== 8'd4) begin
      bad++;
      $display("FAIL done_ignore: done=%b cyc=%0d ch0=%0d, want 1/4/4", done, cycle_cnt, rd_err_cnt);
    end
    do_clear();
    win_len = 8'd50; start = 1'b1; err_in = 4'b1111;
    for (int k = 0; k < 8; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({rd_err_cnt, cycle_cnt, busy, done, cnt_full, any_sat} !== '0) begin
      bad++;
      $display("FAIL async_reset: rd=%0d cyc=%0d busy=%b done=%b, want all 0", rd_err_cnt, cycle_cnt, busy, done);
    end
    err_in = '0; start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 3000; k++) begin
      clear   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 40) == 0) mode = ~mode;
      win_len = 8'($urandom_range(0, 30));
      err_in  = 4'($urandom);
      ch_sel  = 3'($urandom_range(0, 7));
      tick();
      total++;
      if (rd_err_cnt !== CNTW'(m_rd) || cycle_cnt !== CNTW'(m_cyc) ||
          busy !== (m_phase == PH_RUN) || done !== (m_phase == PH_DONE) ||
          cnt_full !== m_full || any_sat !== m_anysat) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL random@%0d: rd=%0d/%0d cyc=%0d/%0d busy=%b done=%b full=%b sat=%b phase_req=%0d full_req=%b sat_req=%b",
                   k, rd_err_cnt, m_rd, cycle_cnt, m_cyc, busy, done, cnt_full, any_sat,
                   m_phase, m_full, m_anysat);
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_window();
    test_level();
    test_saturation();
    test_clear();
    test_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
